// File: rtl/jt12_eg_ring.sv
// jt12_eg_ring: per-slot envelope state ring plus the global envelope timer.
// The ring holds {state, eg, ssg_inv, cnt_lsb, key} for every operator slot.
// The head entry feeds the combinational envelope stage, and that stage's
// results come back in at the tail. Optional build macro JT12_EG_FASTCNT_EN
// bypasses the divider so that eg_cnt steps on every zero pulse.
module jt12_eg_ring #(
    parameter int SLOTS = 24,
    parameter int CNT_W = 15,
    parameter int DIV   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             zero,
    input  logic             keyon_I,
    input  logic [2:0]       state_next,
    input  logic [9:0]       eg_next,
    input  logic             ssg_inv_out,
    input  logic             cnt_lsb,
    output logic [2:0]       state_in,
    output logic [9:0]       eg_in,
    output logic             ssg_inv_in,
    output logic             cnt_in,
    output logic             keyon_now,
    output logic             keyoff_now,
    output logic [CNT_W-1:0] eg_cnt
);

    typedef struct packed {
        logic [2:0] state;
        logic [9:0] eg;
        logic       ssg_inv;
        logic       cnt;
        logic       key;
    } slot_t;

    // Cleared slot: release state, full attenuation, key up.
    localparam slot_t SLOT_RST = '{state: 3'b000, eg: 10'h3FF, ssg_inv: 1'b0,
                                   cnt: 1'b0, key: 1'b0};

    slot_t            ring_r [SLOTS];
    slot_t            tail_s;
    logic [CNT_W-1:0] eg_cnt_r;

    // Pack the envelope stage results together with this cycle's key bit.
    always_comb begin
        tail_s = '{state: state_next, eg: eg_next, ssg_inv: ssg_inv_out,
                   cnt: cnt_lsb, key: keyon_I};
    end

    // Rotate the ring one slot per clk_en; reset clears every entry at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                ring_r[i] <= SLOT_RST;
            end
        end else if (clk_en) begin
            for (int i = 0; i < SLOTS - 1; i++) begin
                ring_r[i] <= ring_r[i+1];
            end
            ring_r[SLOTS-1] <= tail_s;
        end
    end

    // The head entry is itself a flop, so these outputs are registered.
    assign state_in   = ring_r[0].state;
    assign eg_in      = ring_r[0].eg;
    assign ssg_inv_in = ring_r[0].ssg_inv;
    assign cnt_in     = ring_r[0].cnt;

    // Key edges compare the live key bit against the key stored last revolution.
    assign keyon_now  =  keyon_I & ~ring_r[0].key;
    assign keyoff_now = ~keyon_I &  ring_r[0].key;

`ifdef JT12_EG_FASTCNT_EN
    // Fast build: the global counter steps on every qualified zero pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            eg_cnt_r <= {CNT_W{1'b0}};
        end else if (clk_en && zero) begin
            eg_cnt_r <= eg_cnt_r + CNT_W'(1);
        end
    end
`else
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DIV_W-1:0] div_r;
    logic             div_wrap_s;

    assign div_wrap_s = (div_r == DIV_W'(DIV - 1));

    // Divide qualified zero pulses by DIV; the counter steps when the divider wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r    <= {DIV_W{1'b0}};
            eg_cnt_r <= {CNT_W{1'b0}};
        end else if (clk_en && zero) begin
            if (div_wrap_s) begin
                div_r    <= {DIV_W{1'b0}};
                eg_cnt_r <= eg_cnt_r + CNT_W'(1);
            end else begin
                div_r    <= div_r + DIV_W'(1);
            end
        end
    end
`endif

    assign eg_cnt = eg_cnt_r;

endmodule
